// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg
//   Shared types and default parameter values for the clock-enable generator.
//   - state_e         : lock FSM encoding (WAIT_LOCK, LOCKED, RELOCK)
//   - DEF_*           : default values for the clk_gen / clk_gen_channel parameters
//   - LOCK_CNT_W      : lock counter width, wide enough for LOCK_CYCLES up to 65535
package clk_gen_pkg;

  typedef enum logic [1:0] {
    ST_WAIT_LOCK = 2'd0,
    ST_LOCKED    = 2'd1,
    ST_RELOCK    = 2'd2
  } state_e;

  localparam int DEF_NUM_CH      = 4;
  localparam int DEF_DIV_W       = 8;
  localparam int DEF_LOCK_CYCLES = 16;
  localparam int DEF_DIV_VAL     = 2;
  localparam int LOCK_CNT_W      = 16;

endpackage : clk_gen_pkg

// File: rtl/clk_gen_channel.sv
// clk_gen_channel
//   One clock-enable channel: divisor/phase configuration registers, a phase
//   counter and the ce/sq decode.
//   Ports:
//     clk, rst_n  : clock, asynchronous active-low reset
//     wr_i        : load div_i/phase_i into the configuration registers
//     div_i       : new divisor (0 disables the channel)
//     phase_i     : new counter start value
//     load_i      : the FSM is entering LOCKED on this edge; start counter at phase
//     run_i       : FSM is in LOCKED (registered state decode)
//     ce_o        : clock-enable pulse, high when counter = div-1
//     sq_o        : square wave, high while counter < ceil(div/2)
module clk_gen_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_W   = DEF_DIV_W,
  parameter int DEF_DIV = DEF_DIV_VAL
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_i,
  input  logic [DIV_W-1:0] div_i,
  input  logic [DIV_W-1:0] phase_i,
  input  logic             load_i,
  input  logic             run_i,
  output logic             ce_o,
  output logic             sq_o
);

  localparam int HW = DIV_W + 1;

  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] phase_q, phase_d;
  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [HW-1:0]    half_s;
  logic             at_last_s;

  // Extra bit keeps ceil(div/2) exact for div = 2^DIV_W-1.
  assign half_s    = ({1'b0, div_q} + HW'(1)) >> 1;
  assign at_last_s = (div_q != '0) && (cnt_q == (div_q - DIV_W'(1)));

  // Next-state logic for configuration registers and phase counter.
  always_comb begin
    div_d   = div_q;
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (wr_i) begin
      div_d   = div_i;
      phase_d = phase_i;
    end else begin
      div_d   = div_q;
      phase_d = phase_q;
    end
    // load and run are never both set: load only happens outside LOCKED.
    if (load_i) begin
      cnt_d = (phase_q < div_q) ? phase_q : '0;
    end else if (run_i) begin
      if (div_q == '0) begin
        cnt_d = '0;
      end else if (at_last_s) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + DIV_W'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Channel state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q   <= DIV_W'(DEF_DIV);
      phase_q <= '0;
      cnt_q   <= '0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode registers only; run_i is itself a registered-state decode.
  assign ce_o = run_i && at_last_s;
  assign sq_o = run_i && ({1'b0, cnt_q} < half_s);

endmodule : clk_gen_channel

// File: rtl/clk_gen.sv
// clk_gen
//   Multi-channel clock-enable generator with a settle/lock FSM. Any valid
//   configuration write or sync request drops lock for LOCK_CYCLES cycles, after
//   which all channels restart aligned on the same edge.
//   Ports:
//     clk, rst_n  : sole clock, asynchronous active-low reset
//     cfg_valid   : configuration request
//     cfg_ready   : high in LOCKED; transfer when cfg_valid && cfg_ready
//     cfg_ch      : target channel (indices >= NUM_CH are accepted and ignored)
//     cfg_div     : new divisor (0 disables the channel)
//     cfg_phase   : counter start value applied on lock
//     sync_req    : realign all channels
//     ce          : per-channel clock-enable pulses
//     sq          : per-channel square waves
//     locked      : outputs valid
module clk_gen
  import clk_gen_pkg::*;
#(
  parameter  int NUM_CH      = DEF_NUM_CH,
  parameter  int DIV_W       = DEF_DIV_W,
  parameter  int LOCK_CYCLES = DEF_LOCK_CYCLES,
  parameter  int DEF_DIV     = DEF_DIV_VAL,
  localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [DIV_W-1:0]  cfg_div,
  input  logic [DIV_W-1:0]  cfg_phase,
  input  logic              sync_req,
  output logic [NUM_CH-1:0] ce,
  output logic [NUM_CH-1:0] sq,
  output logic              locked
);

  localparam logic [LOCK_CNT_W-1:0] LOCK_LAST = LOCK_CNT_W'(LOCK_CYCLES - 1);
  localparam logic [CH_W:0]         NUM_CH_L  = (CH_W + 1)'(NUM_CH);

  state_e                  state_q, state_d;
  logic [LOCK_CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic                    in_locked_s;
  logic                    ch_ok_s;
  logic                    xfer_s;
  logic                    cfg_wr_s;
  logic                    load_s;

  assign in_locked_s = (state_q == ST_LOCKED);
  assign ch_ok_s     = ({1'b0, cfg_ch} < NUM_CH_L);
  assign xfer_s      = in_locked_s && cfg_valid;
  assign cfg_wr_s    = xfer_s && ch_ok_s;
  // Channels start their counters on the same edge the FSM enters LOCKED.
  assign load_s      = !in_locked_s && (state_d == ST_LOCKED);

  // Lock FSM next-state and lock counter.
  always_comb begin
    state_d    = state_q;
    lock_cnt_d = lock_cnt_q;
    case (state_q)
      ST_WAIT_LOCK, ST_RELOCK: begin
        if (sync_req) begin
          lock_cnt_d = '0;
        end else if (lock_cnt_q == LOCK_LAST) begin
          state_d    = ST_LOCKED;
          lock_cnt_d = '0;
        end else begin
          lock_cnt_d = lock_cnt_q + LOCK_CNT_W'(1);
        end
      end
      ST_LOCKED: begin
        // A write and a sync on the same edge still produce a single RELOCK.
        if (cfg_wr_s || sync_req) begin
          state_d    = ST_RELOCK;
          lock_cnt_d = '0;
        end else begin
          state_d    = ST_LOCKED;
          lock_cnt_d = lock_cnt_q;
        end
      end
      default: begin
        state_d    = ST_WAIT_LOCK;
        lock_cnt_d = '0;
      end
    endcase
  end

  // Lock FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_WAIT_LOCK;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign locked    = in_locked_s;
  assign cfg_ready = in_locked_s;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    localparam logic [CH_W-1:0] IDX = CH_W'(g);

    clk_gen_channel #(
      .DIV_W   (DIV_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_i    (cfg_wr_s && (cfg_ch == IDX)),
      .div_i   (cfg_div),
      .phase_i (cfg_phase),
      .load_i  (load_s),
      .run_i   (in_locked_s),
      .ce_o    (ce[g]),
      .sq_o    (sq[g])
    );
  end

endmodule : clk_gen

// File: tb/tb_clk_gen.sv
// tb_clk_gen
//   Directed bench for clk_gen. Five channels are used so that an out-of-range
//   channel index (5, 7) is representable in cfg_ch; with four channels CH_W is
//   2 and index 5 cannot be driven. Inputs change and outputs are sampled on
//   the falling edge.
module tb_clk_gen;

  localparam int NCH = 5;

  logic           clk;
  logic           rst_n;
  logic           cfg_valid;
  logic           cfg_ready;
  logic [2:0]     cfg_ch;
  logic [7:0]     cfg_div;
  logic [7:0]     cfg_phase;
  logic           sync_req;
  logic [NCH-1:0] ce;
  logic [NCH-1:0] sq;
  logic           locked;

  int n_vec;
  int n_miss;

  clk_gen #(
    .NUM_CH      (NCH),
    .DIV_W       (8),
    .LOCK_CYCLES (16),
    .DEF_DIV     (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_phase (cfg_phase),
    .sync_req  (sync_req),
    .ce        (ce),
    .sq        (sq),
    .locked    (locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One rising edge, then park on the following falling edge.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  // Called right after the edge that left LOCKED: 15 more edges keep lock low,
  // the 16th brings it back.
  task automatic expect_relock(input string tag);
    step(15);
    chk({tag, "_low15"}, 32'(locked), 32'd0);
    step(1);
    chk({tag, "_high16"}, 32'(locked), 32'd1);
  endtask

  task automatic write_cfg(input logic [2:0] ch, input logic [7:0] dv, input logic [7:0] ph);
    cfg_valid = 1'b1;
    cfg_ch    = ch;
    cfg_div   = dv;
    cfg_phase = ph;
    step(1);
    cfg_valid = 1'b0;
  endtask

  // ch1 div4 ph3, others div2 ph0: relock cycles 0..4.
  logic [NCH-1:0] ce_t1 [5];
  logic [NCH-1:0] sq_t1 [5];
  logic [3:0]     ce0_t4;
  logic [3:0]     sq0_t4;

  initial begin
    n_vec     = 0;
    n_miss    = 0;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_ch    = 3'd0;
    cfg_div   = 8'd0;
    cfg_phase = 8'd0;
    sync_req  = 1'b0;

    ce_t1[0] = 5'b00010; sq_t1[0] = 5'b11101;
    ce_t1[1] = 5'b11101; sq_t1[1] = 5'b00010;
    ce_t1[2] = 5'b00000; sq_t1[2] = 5'b11111;
    ce_t1[3] = 5'b11101; sq_t1[3] = 5'b00000;
    ce_t1[4] = 5'b00010; sq_t1[4] = 5'b11101;
    ce0_t4   = 4'b1000;  // bit k = cycle k, ch0 div4 with clamped phase
    sq0_t4   = 4'b0011;

    // Reset state
    step(2);
    chk("rst_locked", 32'(locked), 32'd0);
    chk("rst_ready", 32'(cfg_ready), 32'd0);
    chk("rst_ce", 32'(ce), 32'd0);
    chk("rst_sq", 32'(sq), 32'd0);

    // Initial lock: 16 edges after release
    rst_n = 1'b1;
    expect_relock("init");
    chk("init_ready", 32'(cfg_ready), 32'd1);
    chk("init_ce0", 32'(ce), 32'h00);
    chk("init_sq0", 32'(sq), 32'h1f);
    step(1);
    chk("init_ce1", 32'(ce), 32'h1f);
    chk("init_sq1", 32'(sq), 32'h00);
    step(1);
    chk("init_ce2", 32'(ce), 32'h00);

    // ch1 div=4 phase=3
    write_cfg(3'd1, 8'd4, 8'd3);
    chk("wr1_dropped", 32'(locked), 32'd0);
    expect_relock("wr1");
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("wr1_ce_k%0d", k), 32'(ce), 32'(ce_t1[k]));
      chk($sformatf("wr1_sq_k%0d", k), 32'(sq), 32'(sq_t1[k]));
      if (k < 4) step(1);
    end

    // Out-of-range channel: accepted, ignored, lock kept
    write_cfg(3'd5, 8'd7, 8'd0);
    chk("oor5_locked", 32'(locked), 32'd1);
    chk("oor5_ce", 32'(ce), 32'h1d);
    chk("oor5_sq", 32'(sq), 32'h02);
    write_cfg(3'd7, 8'd0, 8'd0);
    chk("oor7_locked", 32'(locked), 32'd1);
    chk("oor7_ce", 32'(ce), 32'h00);
    chk("oor7_sq", 32'(sq), 32'h1f);

    // Write + sync on one edge, then sync again 5 edges into RELOCK
    sync_req = 1'b1;
    write_cfg(3'd0, 8'd3, 8'd1);
    sync_req = 1'b0;
    step(4);
    sync_req = 1'b1;
    step(1);
    sync_req = 1'b0;
    expect_relock("sync2");
    chk("sync2_ce0", 32'(ce), 32'h02);
    chk("sync2_sq0", 32'(sq), 32'h1d);
    step(1);
    chk("sync2_ce1", 32'(ce), 32'h1d);
    chk("sync2_sq1", 32'(sq), 32'h02);

    // ch0 div=0: disabled
    write_cfg(3'd0, 8'd0, 8'd0);
    expect_relock("div0");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("div0_ce_k%0d", k), 32'(ce[0]), 32'd0);
      chk($sformatf("div0_sq_k%0d", k), 32'(sq[0]), 32'd0);
      step(1);
    end

    // ch0 div=1: always high
    write_cfg(3'd0, 8'd1, 8'd0);
    expect_relock("div1");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("div1_ce_k%0d", k), 32'(ce[0]), 32'd1);
      chk($sformatf("div1_sq_k%0d", k), 32'(sq[0]), 32'd1);
      step(1);
    end

    // ch0 div=4 phase=7: phase out of range loads 0
    write_cfg(3'd0, 8'd4, 8'd7);
    expect_relock("ph7");
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ph7_ce_k%0d", k), 32'(ce[0]), 32'(ce0_t4[k]));
      chk($sformatf("ph7_sq_k%0d", k), 32'(sq[0]), 32'(sq0_t4[k]));
      step(1);
    end

    // Reset pulsed mid-RELOCK
    write_cfg(3'd2, 8'd5, 8'd0);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("midrst_locked", 32'(locked), 32'd0);
    chk("midrst_ready", 32'(cfg_ready), 32'd0);
    chk("midrst_ce", 32'(ce), 32'd0);
    chk("midrst_sq", 32'(sq), 32'd0);
    step(1);
    rst_n = 1'b1;
    expect_relock("postrst");
    chk("postrst_ce0", 32'(ce), 32'h00);
    chk("postrst_sq0", 32'(sq), 32'h1f);
    step(1);
    chk("postrst_ce1", 32'(ce), 32'h1f);
    chk("postrst_sq1", 32'(sq), 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_clk_gen
